fetch_stage: RTL and testbench

Instruction-fetch stage of the 64-bit pipeline, directly upstream of the IF/ID register. Holds the architectural PC and issues word requests to instruction memory over a req/ready handshake. Presents each fetched instruction with its PC and a valid flag to IF/ID. Honours pipeline stall and branch redirect from decode, discarding any response that belongs to the squashed path.

---
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, runs the imem req/ready
// handshake and feeds IF/ID, with stall freezing and redirect squashing.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [63:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [63:0] target_w;

  function automatic logic [63:0] pc_inc(input logic [63:0] a);
    return a + 64'd4;
  endfunction

  function automatic logic [63:0] word_align(input logic [63:0] a);
    return a & ~64'h3;
  endfunction

  assign target_w  = word_align(redirect_target);
  assign imem_req  = (state_q == S_WAIT) || (state_q == S_DROP);
  assign imem_addr = req_addr_q;

  assign instruction_out = instr_q;
  assign pc_out          = pc_out_q;
  assign valid_out       = valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;

    // Bubble unless IF/ID is frozen; a redirect always bubbles, even under stall.
    if (!stall || redirect) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end

    case (state_q)
      S_START: begin
        state_d    = S_WAIT;
        req_addr_d = pc_q;
      end

      S_WAIT: begin
        if (redirect) begin
          pc_d = target_w;
          // A request that completes now can be retired and re-aimed at once;
          // otherwise the pending handshake must finish before we re-aim.
          if (imem_ready) begin
            req_addr_d = target_w;
          end else begin
            state_d = S_DROP;
          end
        end else if (imem_ready) begin
          pc_d = pc_inc(req_addr_q);
          if (!stall) begin
            instr_d    = imem_rdata;
            pc_out_d   = req_addr_q;
            valid_d    = 1'b1;
            req_addr_d = pc_inc(req_addr_q);
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = req_addr_q;
            state_d     = S_HOLD;
          end
        end
      end

      S_DROP: begin
        if (redirect) begin
          pc_d = target_w;
        end
        if (imem_ready) begin
          req_addr_d = redirect ? target_w : pc_q;
          state_d    = S_WAIT;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d       = target_w;
          req_addr_d = target_w;
          state_d    = S_WAIT;
        end else if (!stall) begin
          instr_d    = buf_instr_q;
          pc_out_d   = buf_pc_q;
          valid_d    = 1'b1;
          req_addr_d = pc_q;
          state_d    = S_WAIT;
        end
      end

      default: begin
        state_d = S_START;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_START;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 64'h0;
      instr_q     <= NOP;
      pc_out_q    <= 64'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus acts as instruction memory and
// queues expected IF/ID outputs; a negedge monitor pops and compares them.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [63:0] pc_out;
  logic        valid_out;

  int errors = 0;
  int checks = 0;
  logic [95:0] sb_q[$];

  fetch_stage #(.RESET_PC(64'h0), .NOP(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .valid_out       (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Act as memory for one request: wait for it, hold off lat cycles, respond.
  task automatic serve(input logic [63:0] addr, input logic [31:0] data,
                       input int lat, input bit expect_out);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {63'h0, imem_req}, 64'h1);
    check("req_addr", imem_addr, addr);
    for (int i = 0; i < lat; i++) begin
      tick();
      check("req_held", {63'h0, imem_req}, 64'h1);
      check("addr_held", imem_addr, addr);
      if (!stall) check("wait_bubble", {63'h0, valid_out}, 64'h0);
    end
    imem_ready = 1'b1;
    imem_rdata = data;
    if (expect_out) sb_q.push_back({data, addr});
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    if (!stall) begin
      check("out_valid", {63'h0, valid_out}, {63'h0, expect_out});
      if (expect_out) check("out_pc_now", pc_out, addr);
    end
  endtask

  // Monitor: an output is consumed when IF/ID is not stalling.
  always @(negedge clk) begin
    logic [95:0] e;
    if (rst) begin
      if (valid_out && !stall) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pc=%h instr=%h expected no output", pc_out, instruction_out);
        end else begin
          e = sb_q.pop_front();
          check("mon_instr", {32'h0, instruction_out}, {32'h0, e[95:64]});
          check("mon_pc", pc_out, e[63:0]);
        end
      end else if (!valid_out) begin
        check("bubble_nop", {32'h0, instruction_out}, {32'h0, NOP});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 64'h0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    tick();
    tick();
    check("rst_req", {63'h0, imem_req}, 64'h0);
    check("rst_addr", imem_addr, 64'h0);
    check("rst_instr", {32'h0, instruction_out}, {32'h0, NOP});
    check("rst_pc", pc_out, 64'h0);
    check("rst_valid", {63'h0, valid_out}, 64'h0);
    rst = 1'b1;
    check("start_noreq", {63'h0, imem_req}, 64'h0);

    // Zero-wait stream
    serve(64'h0, 32'hA000_0001, 0, 1);
    serve(64'h4, 32'hA000_0002, 0, 1);
    serve(64'h8, 32'hA000_0003, 0, 1);

    // Three wait states
    serve(64'hC, 32'hA000_0004, 3, 1);
    tick();

    // Stall with response in flight
    stall = 1'b1;
    serve(64'h10, 32'h1122_3344, 0, 1);
    check("hold_noreq", {63'h0, imem_req}, 64'h0);
    check("hold_frozen", {63'h0, valid_out}, 64'h0);
    tick();
    check("hold_noreq2", {63'h0, imem_req}, 64'h0);
    stall = 1'b0;
    tick();
    check("unstall_valid", {63'h0, valid_out}, 64'h1);
    check("unstall_instr", {32'h0, instruction_out}, 64'h1122_3344);
    check("unstall_pc", pc_out, 64'h10);

    serve(64'h14, 32'hA000_0005, 0, 1);
    serve(64'h18, 32'hA000_0006, 0, 1);
    serve(64'h1C, 32'hA000_0007, 0, 1);
    tick();

    // Redirect while waiting on 0x20
    redirect = 1'b1;
    redirect_target = 64'h1234_5678_90AB_CDEF;
    tick();
    redirect = 1'b0;
    check("drop_addr", imem_addr, 64'h20);
    check("drop_valid", {63'h0, valid_out}, 64'h0);
    serve(64'h20, 32'hDEAD_0020, 1, 0);
    serve(64'h1234_5678_90AB_CDEC, 32'hB000_0001, 0, 1);

    // Redirect coinciding with ready in WAIT
    redirect = 1'b1;
    redirect_target = 64'h40;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_CDF0;
    tick();
    redirect = 1'b0;
    imem_ready = 1'b0;
    check("redir_rdy_addr", imem_addr, 64'h40);
    check("redir_rdy_valid", {63'h0, valid_out}, 64'h0);
    serve(64'h40, 32'hB000_0002, 0, 1);
    tick();

    // Redirect while holding a buffered instruction
    stall = 1'b1;
    serve(64'h44, 32'hBAD0_BAD0, 0, 0);
    redirect = 1'b1;
    redirect_target = 64'h100;
    tick();
    check("hold_redir_valid", {63'h0, valid_out}, 64'h0);
    check("hold_redir_nop", {32'h0, instruction_out}, {32'h0, NOP});
    check("hold_redir_addr", imem_addr, 64'h100);
    redirect = 1'b0;
    stall = 1'b0;
    serve(64'h100, 32'hB000_0003, 0, 1);

    // PC wrap at the top of the address space
    redirect = 1'b1;
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect = 1'b0;
    serve(64'h104, 32'hDEAD_0104, 0, 0);
    serve(64'hFFFF_FFFF_FFFF_FFFC, 32'hC000_0001, 0, 1);
    serve(64'h0, 32'hC000_0002, 0, 1);
    tick();

    // Reset mid-request
    check("pre_rst_req", {63'h0, imem_req}, 64'h1);
    rst = 1'b0;
    #1;
    check("midrst_req", {63'h0, imem_req}, 64'h0);
    check("midrst_addr", imem_addr, 64'h0);
    check("midrst_valid", {63'h0, valid_out}, 64'h0);
    check("midrst_pc", pc_out, 64'h0);

    check("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
